// File: rtl/axis_bram_seq.sv
// Job sequencer for an AXI-Stream/BRAM datapath: queues job descriptors, issues them one at a
// time with a start pulse, waits for the stream tlast handshakes, and reports completion/timeout.
module axis_bram_seq #(
  parameter int ADDR_WIDTH = 12,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_r_start,
  input  logic [ADDR_WIDTH-1:0] cmd_r_length,
  input  logic [ADDR_WIDTH-1:0] cmd_w_start,
  input  logic                  cmd_w_en,
  input  logic                  abort,
  output logic                  ctrl_axis_m_start,
  output logic [ADDR_WIDTH-1:0] ctrl_r_start_index,
  output logic [ADDR_WIDTH-1:0] ctrl_r_length,
  output logic [ADDR_WIDTH-1:0] ctrl_w_start_index,
  input  logic                  mon_m_tvalid,
  input  logic                  mon_m_tready,
  input  logic                  mon_m_tlast,
  input  logic                  mon_s_tvalid,
  input  logic                  mon_s_tready,
  input  logic                  mon_s_tlast,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  err_timeout,
  output logic [15:0]           jobs_done,
  output logic [1:0]            state_dbg
);

  // Handshake rule: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on FIFO fullness, never on a same-cycle pop.
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int EW = 3 * ADDR_WIDTH + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t          state, state_n;
  logic [EW-1:0]   fifo_mem [CMD_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            full, empty, push, pop;
  logic [EW-1:0]   head;
  logic            ctrl_w_en;
  logic            rd_done, wr_done, rd_n, wr_n;
  logic [TW-1:0]   tcnt;
  logic            timeout_hit;

  assign full      = (count == (PW+1)'(CMD_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready && !abort;
  assign pop       = (state == IDLE) && !empty && !abort;
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_r_start, cmd_r_length, cmd_w_start, cmd_w_en};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  assign rd_n = rd_done || (mon_m_tvalid && mon_m_tready && mon_m_tlast);
  assign wr_n = wr_done || (mon_s_tvalid && mon_s_tready && mon_s_tlast);

  always_comb begin
    state_n     = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:  if (!empty) state_n = ISSUE;
      ISSUE: state_n = RUN;
      RUN: begin
        // Completion wins over a timeout landing in the same cycle.
        if (rd_n && wr_n) begin
          state_n = DONE;
        end else if ((TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1))) begin
          state_n     = IDLE;
          timeout_hit = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      rd_done            <= 1'b0;
      wr_done            <= 1'b0;
      tcnt               <= '0;
      err_timeout        <= 1'b0;
      jobs_done          <= '0;
      ctrl_r_start_index <= '0;
      ctrl_r_length      <= '0;
      ctrl_w_start_index <= '0;
      ctrl_w_en          <= 1'b0;
    end else begin
      state <= state_n;
      if (pop) begin
        ctrl_r_start_index <= head[EW-1 -: ADDR_WIDTH];
        ctrl_r_length      <= head[2*ADDR_WIDTH -: ADDR_WIDTH];
        ctrl_w_start_index <= head[ADDR_WIDTH:1];
        ctrl_w_en          <= head[0];
      end
      if (state == ISSUE) begin
        rd_done <= (ctrl_r_length == '0);
        wr_done <= !ctrl_w_en;
        tcnt    <= '0;
      end else if (state == RUN) begin
        rd_done <= rd_n;
        wr_done <= wr_n;
        tcnt    <= tcnt + TW'(1);
      end
      if (abort)            err_timeout <= 1'b0;
      else if (timeout_hit) err_timeout <= 1'b1;
      if ((state == DONE) && !abort) jobs_done <= jobs_done + 16'd1;
    end
  end

  assign ctrl_axis_m_start = (state == ISSUE);
  assign done_pulse        = (state == DONE) && !abort;
  assign busy              = (state != IDLE) || !empty;
  assign state_dbg         = state;

endmodule

// File: tb/tb_axis_bram_seq.sv
// Self-checking bench for axis_bram_seq: directed scenarios plus randomized jobs checked
// against a descriptor queue and job-timing rules computed in the bench.
module tb_axis_bram_seq;
  localparam int AW = 12;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_w_en = 1'b0, abort = 1'b0;
  logic [AW-1:0] cmd_r_start = '0, cmd_r_length = '0, cmd_w_start = '0;
  logic mon_m_tvalid = 1'b0, mon_m_tready = 1'b0, mon_m_tlast = 1'b0;
  logic mon_s_tvalid = 1'b0, mon_s_tready = 1'b0, mon_s_tlast = 1'b0;
  logic cmd_ready, ctrl_axis_m_start, busy, done_pulse, err_timeout;
  logic [AW-1:0] ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index;
  logic [15:0] jobs_done;
  logic [1:0]  state_dbg;

  int vectors = 0, miscompares = 0;
  int cyc = 0, s_cyc = 0, start_cnt = 0, last_start_cyc = 0, exp_jobs = 0;
  logic [3*AW:0] exp_q[$];

  axis_bram_seq #(.ADDR_WIDTH(AW), .CMD_DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_r_start(cmd_r_start), .cmd_r_length(cmd_r_length), .cmd_w_start(cmd_w_start),
    .cmd_w_en(cmd_w_en), .abort(abort), .ctrl_axis_m_start(ctrl_axis_m_start),
    .ctrl_r_start_index(ctrl_r_start_index), .ctrl_r_length(ctrl_r_length),
    .ctrl_w_start_index(ctrl_w_start_index),
    .mon_m_tvalid(mon_m_tvalid), .mon_m_tready(mon_m_tready), .mon_m_tlast(mon_m_tlast),
    .mon_s_tvalid(mon_s_tvalid), .mon_s_tready(mon_s_tready), .mon_s_tlast(mon_s_tlast),
    .busy(busy), .done_pulse(done_pulse), .err_timeout(err_timeout),
    .jobs_done(jobs_done), .state_dbg(state_dbg)
  );

  // clock / cycle counter / start-pulse monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ctrl_axis_m_start === 1'b1) begin
    start_cnt      <= start_cnt + 1;
    last_start_cyc <= cyc;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    {mon_m_tvalid, mon_m_tready, mon_m_tlast} = 3'b000;
    {mon_s_tvalid, mon_s_tready, mon_s_tlast} = 3'b000;
  endtask

  // driver: push one descriptor {r_start, r_length, w_start, w_en}
  task automatic push_cmd(input logic [3*AW:0] d);
    int n = 0;
    {cmd_r_start, cmd_r_length, cmd_w_start, cmd_w_en} = d;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 40) begin tick(); n++; end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL push_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // driver: wait for a start pulse, bounded
  task automatic wait_start(output int n);
    n = 0;
    while (ctrl_axis_m_start !== 1'b1 && n < 60) begin tick(); n++; end
    vectors++;
    if (ctrl_axis_m_start !== 1'b1) begin
      miscompares++; $display("FAIL start_wait: no start pulse within %0d cycles", n);
    end
    s_cyc = cyc;
  endtask

  // driver: finish the running job; tlast handshakes land at RUN cycles km/ks (0 = not needed).
  // Expected DONE is one cycle after the later handshake, or the 2nd cycle after ISSUE.
  task automatic run_job(input int km, input int ks);
    int total = ((km > ks ? km : ks) > 1 ? (km > ks ? km : ks) : 1) + 1;
    int k;
    while (cyc < s_cyc + total) begin
      tick();
      k = cyc - s_cyc;
      clear_mon();
      if (k < total) begin
        if (k == km) {mon_m_tvalid, mon_m_tready, mon_m_tlast} = 3'b111;
        else begin
          {mon_m_tvalid, mon_m_tready, mon_m_tlast} = 3'($urandom_range(0, 7));
          if (mon_m_tvalid && mon_m_tready) mon_m_tlast = 1'b0;
        end
        if (k == ks) {mon_s_tvalid, mon_s_tready, mon_s_tlast} = 3'b111;
        else begin
          {mon_s_tvalid, mon_s_tready, mon_s_tlast} = 3'($urandom_range(0, 7));
          if (mon_s_tvalid && mon_s_tready) mon_s_tlast = 1'b0;
        end
      end
      vectors++;
      if ({done_pulse, ctrl_axis_m_start} !== {(k == total), 1'b0}) begin
        miscompares++;
        $display("FAIL job_timing: RUN+%0d done/start=%b%b, required %b0", k, done_pulse, ctrl_axis_m_start, (k == total));
      end
    end
    clear_mon();
    tick();
    exp_jobs++;
    vectors++;
    if (jobs_done !== 16'(exp_jobs)) begin
      miscompares++; $display("FAIL jobs_done: got %0d, required %0d", jobs_done, exp_jobs);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({cmd_ready, ctrl_axis_m_start, ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index,
         busy, done_pulse, err_timeout, jobs_done, state_dbg} !== '0) begin
      miscompares++; $display("FAIL reset_values: some output nonzero (ready=%b busy=%b jobs=%0d)", cmd_ready, busy, jobs_done);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({cmd_ready, busy} !== 2'b10) begin
      miscompares++; $display("FAIL reset_release: ready/busy=%b%b, required 10", cmd_ready, busy);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [3*AW:0] d = {12'h010, 12'd8, 12'h100, 1'b1};
    int n, sc = start_cnt;
    push_cmd(d);
    wait_start(n);
    vectors++;
    if ({ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index} !== d[3*AW:1]) begin
      miscompares++; $display("FAIL basic_fields: got %h/%h/%h, required 010/008/100", ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index);
    end
    run_job(10, 12);
    vectors++;
    if (start_cnt !== sc + 1) begin
      miscompares++; $display("FAIL basic_starts: %0d start pulses, required 1", start_cnt - sc);
    end
  endtask

  task automatic test_zero_len();
    logic [3*AW:0] d = {12'h055, 12'd0, 12'h066, 1'b0};
    int n;
    push_cmd(d);
    wait_start(n);
    vectors++;
    if (n !== 1) begin
      miscompares++; $display("FAIL zero_issue_latency: start %0d cycles after pop, required 1", n);
    end
    vectors++;
    if ({ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index} !== d[3*AW:1]) begin
      miscompares++; $display("FAIL zero_fields: got %h/%h/%h", ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index);
    end
    run_job(0, 0);
  endtask

  task automatic test_fifo_full();
    logic [3*AW:0] d;
    int n, sc = start_cnt;
    for (int i = 0; i < 5; i++) begin
      d = {12'(12'h300 + i), 12'(i + 1), 12'(12'h700 + i), 1'b1};
      exp_q.push_back(d);
      push_cmd(d);
    end
    vectors++;
    if ({cmd_ready, busy} !== 2'b01 || start_cnt !== sc + 1) begin
      miscompares++; $display("FAIL fifo_full: ready/busy=%b%b starts=%0d, required 01 and 1 start", cmd_ready, busy, start_cnt - sc);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) s_cyc = last_start_cyc;
      else wait_start(n);
      d = exp_q.pop_front();
      vectors++;
      if ({ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index} !== d[3*AW:1]) begin
        miscompares++; $display("FAIL fifo_order: job %0d got %h/%h/%h, required %h", i, ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index, d[3*AW:1]);
      end
      if (i == 0) run_job(cyc - s_cyc + 1, cyc - s_cyc + 2);
      else run_job($urandom_range(1, 12), $urandom_range(1, 12));
    end
  endtask

  task automatic test_timeout();
    logic [3*AW:0] a = {12'h200, 12'd5, 12'h300, 1'b1};
    logic [3*AW:0] b = {12'h020, 12'd0, 12'h040, 1'b1};
    int n;
    push_cmd(a);
    push_cmd(b);
    wait_start(n);
    for (int j = 1; j <= 17; j++) begin
      tick();
      vectors++;
      if ({done_pulse, err_timeout} !== {1'b0, (j == 17)} || jobs_done !== 16'(exp_jobs)) begin
        miscompares++; $display("FAIL timeout: RUN+%0d done/err=%b%b jobs=%0d, required 0%b jobs=%0d", j, done_pulse, err_timeout, jobs_done, (j == 17), exp_jobs);
      end
    end
    wait_start(n);
    vectors++;
    if (n !== 1 || {ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index} !== b[3*AW:1]) begin
      miscompares++; $display("FAIL timeout_next: start after %0d cycles fields %h/%h/%h", n, ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index);
    end
    run_job(0, 6);
    vectors++;
    if (err_timeout !== 1'b1) begin
      miscompares++; $display("FAIL err_sticky: err_timeout=%b, required 1", err_timeout);
    end
  endtask

  task automatic test_abort();
    int n, sc;
    push_cmd({12'h111, 12'd3, 12'h222, 1'b1});
    push_cmd({12'h112, 12'd3, 12'h223, 1'b1});
    push_cmd({12'h113, 12'd3, 12'h224, 1'b1});
    vectors++;
    if ({busy, err_timeout, state_dbg} !== {2'b11, 2'd2}) begin
      miscompares++; $display("FAIL abort_pre: busy/err=%b%b state=%0d, required 11 state 2", busy, err_timeout, state_dbg);
    end
    abort = 1'b1;
    {cmd_r_start, cmd_r_length, cmd_w_start, cmd_w_en} = {12'h444, 12'd0, 12'h555, 1'b0};
    cmd_valid = 1'b1;
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    sc = start_cnt;
    vectors++;
    if ({state_dbg, busy, err_timeout, done_pulse} !== 5'b0) begin
      miscompares++; $display("FAIL abort_flush: state=%0d busy=%b err=%b done=%b, required all 0", state_dbg, busy, err_timeout, done_pulse);
    end
    for (n = 0; n < 8; n++) begin
      tick();
      vectors++;
      if ({done_pulse, busy} !== 2'b00 || start_cnt !== sc) begin
        miscompares++; $display("FAIL abort_quiet: done/busy=%b%b starts=%0d, required 00 and 0 starts", done_pulse, busy, start_cnt - sc);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3*AW:0] d = {12'h0AB, 12'd2, 12'h0CD, 1'b1};
    int n, sc;
    push_cmd({12'h123, 12'd4, 12'h456, 1'b1});
    push_cmd({12'h321, 12'd4, 12'h654, 1'b1});
    tick(); tick();
    reset = 1'b1;
    #1;
    vectors++;
    if ({cmd_ready, ctrl_axis_m_start, ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index,
         busy, done_pulse, err_timeout, jobs_done, state_dbg} !== '0) begin
      miscompares++; $display("FAIL reset_mid: outputs not at reset values (ready=%b busy=%b state=%0d jobs=%0d)", cmd_ready, busy, state_dbg, jobs_done);
    end
    exp_jobs = 0;
    tick(); tick();
    reset = 1'b0;
    sc = start_cnt;
    repeat (10) tick();
    vectors++;
    if (start_cnt !== sc || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_lost: starts=%0d busy=%b, required 0 starts busy 0", start_cnt - sc, busy);
    end
    push_cmd(d);
    wait_start(n);
    vectors++;
    if ({ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index} !== d[3*AW:1]) begin
      miscompares++; $display("FAIL reset_new_fields: got %h/%h/%h", ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index);
    end
    run_job(3, 5);
  endtask

  task automatic test_random();
    logic [3*AW:0] d;
    int n, cnt;
    for (int r = 0; r < 8; r++) begin
      cnt = $urandom_range(1, 3);
      for (int i = 0; i < cnt; i++) begin
        d[3*AW -: AW]   = 12'($urandom_range(0, 4095));
        d[2*AW -: AW]   = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
        d[AW:1]         = 12'($urandom_range(0, 4095));
        d[0]            = 1'($urandom_range(0, 1));
        exp_q.push_back(d);
      end
      push_cmd(exp_q[0]);
      for (int i = 0; i < cnt; i++) begin
        wait_start(n);
        d = exp_q.pop_front();
        vectors++;
        if ({ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index} !== d[3*AW:1]) begin
          miscompares++; $display("FAIL rand_fields: round %0d job %0d got %h/%h/%h, required %h", r, i, ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index, d[3*AW:1]);
        end
        if (i == 0) for (int j = 0; j < exp_q.size(); j++) push_cmd(exp_q[j]);
        run_job((d[2*AW -: AW] == 0) ? 0 : $urandom_range(4, 12), d[0] ? $urandom_range(4, 12) : 0);
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_zero_len();
    test_fifo_full();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
